// File: rtl/system_mapped_pkg.sv
// system_map_pkg: constants and types shared by the system_mapped subsystem.
//   - CPU-visible register addresses for the UART receive path
//   - bit positions inside the UART_STATUS word
//   - receive state machine encoding
package system_map_pkg;

    localparam logic [15:0] UART_DATA_ADDR   = 16'hFFF0;
    localparam logic [15:0] UART_STATUS_ADDR = 16'hFFF1;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_CLEANUP
    } rx_state_e;

endpackage

// File: rtl/system_mapped_if.sv
// system_mapped_if: 16-bit CPU load/store port.
//   addr   - word address
//   wr_en  - store strobe, wdata is written this cycle
//   rd_en  - load strobe, rdata is valid on the following cycle
//   wdata  - store data
//   rdata  - registered load data
// master = CPU side, slave = peripheral side.
interface system_mapped_if;

    logic [15:0] addr;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (output addr, output wr_en, output rd_en, output wdata, input rdata);
    modport slave  (input addr, input wr_en, input rd_en, input wdata, output rdata);

endinterface

// File: rtl/system_mapped_uart_rx.sv
// uart_rx: 8N1 UART receiver.
//   clock, reset - system clock, synchronous active-high reset
//   rx           - asynchronous serial input, idle high
//   data         - last byte with a good stop bit
//   valid        - one-cycle pulse when data is updated
//   frame_err    - one-cycle pulse when the stop bit was sampled low
module uart_rx
    import system_map_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q, rx_sync_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_sync_q) state_d = RX_START;
            end
            // Mid-start-bit check rejects glitches shorter than half a bit.
            RX_START: begin
                if (clk_cnt_q == HALF_BIT) begin
                    clk_cnt_d = '0;
                    state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            // Counter now restarts at mid-bit, so each FULL_BIT lands mid-bit.
            RX_DATA: begin
                if (clk_cnt_q == FULL_BIT) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = RX_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == FULL_BIT) begin
                    clk_cnt_d = '0;
                    state_d   = RX_CLEANUP;
                    if (rx_sync_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_CLEANUP: state_d = RX_IDLE;
            default:    state_d = RX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= RX_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/system_mapped.sv
// system_mapped: UART receiver + RX FIFO + word RAM behind one CPU port.
//   clock, reset - system clock, synchronous active-high reset
//   rx           - UART serial input
//   bus          - CPU load/store port (slave side)
//   rx_byte      - last good byte received
//   rx_count     - count of good bytes received, wraps
// Map: 0..RAM_WORDS-1 RAM, 0xFFF0 UART_DATA (read pops), 0xFFF1 UART_STATUS
// (write clears sticky flags); everything else reads 0.
module system_mapped
    import system_map_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int RAM_WORDS    = 256,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rx,
    system_mapped_if.slave  bus,
    output logic [7:0]      rx_byte,
    output logic [15:0]     rx_count
);

    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);

    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_frame_err)
    );

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [15:0] ram      [RAM_WORDS];

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_level;
    logic             overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic [15:0]      rdata_q, rdata_d, rx_count_q, rx_count_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             fifo_empty, fifo_full, ram_hit, pop, push;
    logic [RAM_AW-1:0] ram_idx;
    logic [15:0]      status_word;

    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == (FIFO_AW + 1)'(FIFO_DEPTH));
    assign ram_hit    = (bus.addr < 16'(RAM_WORDS));
    assign ram_idx    = bus.addr[RAM_AW-1:0];

    always_comb begin
        pop  = bus.rd_en && (bus.addr == UART_DATA_ADDR) && !fifo_empty;
        // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
        push = rx_valid && (!fifo_full || pop);

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;

        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (bus.wr_en && (bus.addr == UART_STATUS_ADDR)) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (rx_valid && !push) overrun_d   = 1'b1;
        if (rx_frame_err)      frame_err_d = 1'b1;

        rx_byte_d  = rx_byte_q;
        rx_count_d = rx_count_q;
        if (rx_valid) begin
            rx_byte_d  = rx_data;
            rx_count_d = rx_count_q + 16'd1;
        end

        status_word                 = '0;
        status_word[STAT_NOT_EMPTY] = !fifo_empty;
        status_word[STAT_FULL]      = fifo_full;
        status_word[STAT_OVERRUN]   = overrun_q;
        status_word[STAT_FRAME_ERR] = frame_err_q;

        // Read sees pre-write RAM contents, so a same-cycle store returns old data.
        rdata_d = rdata_q;
        if (bus.rd_en) begin
            if (ram_hit)                             rdata_d = ram[ram_idx];
            else if (bus.addr == UART_DATA_ADDR)     rdata_d = fifo_empty ? 16'h0000
                                                               : {8'h00, fifo_mem[rd_ptr_q[FIFO_AW-1:0]]};
            else if (bus.addr == UART_STATUS_ADDR)   rdata_d = status_word;
            else                                     rdata_d = 16'h0000;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= '0;
            rx_byte_q   <= '0;
            rx_count_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rdata_q     <= rdata_d;
            rx_byte_q   <= rx_byte_d;
            rx_count_q  <= rx_count_d;
        end
    end

    // NOTE: storage arrays are not reset; occupancy is tracked by the pointers and RAM is undefined until written.
    always_ff @(posedge clock) begin
        if (push)                  fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= rx_data;
        if (bus.wr_en && ram_hit)  ram[ram_idx] <= bus.wdata;
    end

    assign bus.rdata = rdata_q;
    assign rx_byte   = rx_byte_q;
    assign rx_count  = rx_count_q;

endmodule

// File: tb/tb_system_mapped.sv
// tb_system_mapped: directed self-checking bench for system_mapped.
// Runs with a short bit period so full frames stay cheap to simulate.
module tb_system_mapped;

    localparam int CPB = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx    = 1'b1;
    logic [7:0]  rx_byte;
    logic [15:0] rx_count;
    int          checks = 0;
    int          errors = 0;

    system_mapped_if bus ();

    system_mapped #(.CLKS_PER_BIT(CPB), .RAM_WORDS(256), .FIFO_DEPTH(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .bus      (bus),
        .rx_byte  (rx_byte),
        .rx_count (rx_count)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic bit_time(input logic level);
        rx = level;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clock);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop_bit);
        rx = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clock);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        @(negedge clock);
        bus.rd_en = 1'b0;
        d = bus.rdata;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] w);
        @(negedge clock);
        bus.addr  = a;
        bus.wdata = w;
        bus.wr_en = 1'b1;
        @(negedge clock);
        bus.wr_en = 1'b0;
    endtask

    logic [15:0] d;

    initial begin
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        do_reset();

        // Reset state
        check("reset_rdata", bus.rdata, 16'h0000);
        check("reset_rx_byte", {8'h00, rx_byte}, 16'h0000);
        check("reset_rx_count", rx_count, 16'h0000);
        cpu_read(16'hFFF1, d); check("reset_status", d, 16'h0000);

        // Single byte 0x00
        send_byte(8'h00, 1'b1);
        check("b00_rx_byte", {8'h00, rx_byte}, 16'h0000);
        check("b00_rx_count", rx_count, 16'd1);
        cpu_read(16'hFFF1, d); check("b00_status", d, 16'h0001);
        cpu_read(16'hFFF0, d); check("b00_data", d, 16'h0000);
        cpu_read(16'hFFF1, d); check("b00_status_after", d, 16'h0000);

        // Two bytes buffered, read in order, then empty
        do_reset();
        send_byte(8'hFF, 1'b1);
        send_byte(8'hA5, 1'b1);
        check("two_rx_count", rx_count, 16'd2);
        check("two_rx_byte", {8'h00, rx_byte}, 16'h00A5);
        cpu_read(16'hFFF0, d); check("two_data0", d, 16'h00FF);
        cpu_read(16'hFFF0, d); check("two_data1", d, 16'h00A5);
        cpu_read(16'hFFF0, d); check("two_data_empty", d, 16'h0000);

        // Framing error: sticky, count unchanged, cleared by status write
        send_byte(8'h3C, 1'b0);
        cpu_read(16'hFFF1, d); check("ferr_status", d, 16'h0008);
        check("ferr_rx_count", rx_count, 16'd2);
        check("ferr_rx_byte", {8'h00, rx_byte}, 16'h00A5);
        cpu_write(16'hFFF1, 16'h0000);
        cpu_read(16'hFFF1, d); check("ferr_cleared", d, 16'h0000);

        // 17 bytes into a 16-deep FIFO
        do_reset();
        for (int i = 0; i < 17; i++) send_byte(8'(8'h10 + i), 1'b1);
        cpu_read(16'hFFF1, d); check("ovr_status", d, 16'h0007);
        check("ovr_rx_count", rx_count, 16'd17);
        check("ovr_rx_byte", {8'h00, rx_byte}, 16'h0020);
        for (int i = 0; i < 16; i++) begin
            cpu_read(16'hFFF0, d);
            check($sformatf("ovr_data%0d", i), d, 16'(8'h10 + i));
        end
        cpu_read(16'hFFF1, d); check("ovr_status_drained", d, 16'h0004);

        // RAM access, hold, out-of-map read, write+read same cycle
        cpu_write(16'h0005, 16'h1234);
        cpu_read(16'h0005, d); check("ram_read", d, 16'h1234);
        repeat (3) @(negedge clock);
        check("ram_hold", bus.rdata, 16'h1234);
        cpu_write(16'h00FF, 16'hC0DE);
        cpu_read(16'h00FF, d); check("ram_top", d, 16'hC0DE);
        cpu_read(16'h1000, d); check("unmapped_read", d, 16'h0000);
        @(negedge clock);
        bus.addr = 16'h0005; bus.wdata = 16'hBEEF; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        @(negedge clock);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        check("ram_rw_old", bus.rdata, 16'h1234);
        cpu_read(16'h0005, d); check("ram_rw_new", d, 16'hBEEF);

        // Short glitch on rx is rejected
        @(negedge clock);
        rx = 1'b0;
        repeat (3) @(negedge clock);
        rx = 1'b1;
        repeat (12 * CPB) @(negedge clock);
        check("glitch_rx_count", rx_count, 16'd17);
        cpu_read(16'hFFF1, d); check("glitch_status", d, 16'h0004);

        // Reset mid-frame, then a clean frame
        @(negedge clock);
        bit_time(1'b0);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        rx = 1'b1;
        do_reset();
        check("midrst_rx_count", rx_count, 16'd0);
        repeat (12 * CPB) @(negedge clock);
        check("midrst_idle_count", rx_count, 16'd0);
        send_byte(8'h5A, 1'b1);
        check("midrst_rx_byte", {8'h00, rx_byte}, 16'h005A);
        check("midrst_rx_count2", rx_count, 16'd1);
        cpu_read(16'hFFF0, d); check("midrst_data", d, 16'h005A);
        cpu_read(16'hFFF1, d); check("midrst_status", d, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
